// File: rtl/adc_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_pkg
// Description : Shared types and defaults for the ADC capture sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_capture_pkg;

    // Default width of the shadowed dwell counts and the shared counter
    localparam int c_cnt_w      = 32;
    // Default number of cycles the FIFO arm pulse is held before presampling
    localparam int c_arm_settle = 4;

    // Sequencer states; the encoding is exported directly on state_o
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_PRESAMPLE = 3'd2,
        ST_WAIT_TRIG = 3'd3,
        ST_OFFSET    = 3'd4,
        ST_CAPTURE   = 3'd5,
        ST_DONE      = 3'd6
    } adc_state_e;

endpackage
`default_nettype wire

// File: rtl/capture_dwell_counter.sv
`default_nettype none
// ============================================================================
// Module      : capture_dwell_counter
// Description : Loadable saturating down-counter with zero flag, shared by
//               every timed dwell of the capture sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_dwell_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    input  logic             i_enable,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Load takes priority; otherwise count down and hold at zero (no wrap)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_ctrl
// Description : Capture sequencer for the ADC FIFO: arm/settle, presample
//               fill, trigger wait with optional timeout, post-trigger
//               offset, capture and done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int CNT_W      = c_cnt_w,
    parameter int ARM_SETTLE = c_arm_settle
) (
    input  logic             adc_sampleclk,
    input  logic             reset_i,
    input  logic             arm_i,
    input  logic             abort_i,
    input  logic             trig_i,
    input  logic             stream_mode_i,
    input  logic [CNT_W-1:0] presample_i,
    input  logic [CNT_W-1:0] offset_i,
    input  logic [CNT_W-1:0] timeout_i,
    input  logic             capture_stop_i,
    output logic             arm_o,
    output logic             capture_go_o,
    output logic             capture_armed_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timed_out_o,
    output logic             overflow_o,
    output logic [2:0]       state_o
);

    // The counter is loaded with N-1 so that a dwell of N lasts exactly N
    // cycles and leaves on the zero flag; a dwell of 0 behaves like 1.
    localparam logic [CNT_W-1:0] c_settle_load =
        (ARM_SETTLE == 0) ? '0 : CNT_W'(ARM_SETTLE - 1);

    function automatic logic [CNT_W-1:0] dwell_load(input logic [CNT_W-1:0] n);
        return (n == '0) ? '0 : n - CNT_W'(1);
    endfunction

    adc_state_e       r_state;
    logic             r_trig_q;
    logic             r_arm_q;
    logic [CNT_W-1:0] r_presample;
    logic [CNT_W-1:0] r_offset;
    logic [CNT_W-1:0] r_timeout;
    logic             r_stream;
    logic             r_arm;
    logic             r_go;
    logic             r_armed;
    logic             r_busy;
    logic             r_done;
    logic             r_timed_out;
    logic             r_overflow;

    adc_state_e       w_nxt;
    adc_state_e       w_after_trig;
    logic             w_trig_edge;
    logic             w_arm_edge;
    logic             w_cnt_zero;
    logic             w_load;
    logic [CNT_W-1:0] w_load_value;
    logic             w_arm_start;
    logic             w_set_timeout;
    logic             w_set_overflow;

    assign w_trig_edge  = trig_i & ~r_trig_q;
    assign w_arm_edge   = arm_i & ~r_arm_q;
    assign w_after_trig = (r_offset == '0) ? ST_CAPTURE : ST_OFFSET;

    capture_dwell_counter #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk          (adc_sampleclk),
        .rst          (reset_i),
        .i_load       (w_load),
        .i_load_value (w_load_value),
        .i_enable     (1'b1),
        .o_zero       (w_cnt_zero)
    );

    // Next-state decision with abort > trigger > timeout > dwell precedence,
    // plus the counter reload for whichever state is being entered
    always_comb begin
        w_nxt          = r_state;
        w_arm_start    = 1'b0;
        w_set_timeout  = 1'b0;
        w_set_overflow = 1'b0;
        if (abort_i) begin
            w_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arm_edge) begin
                        w_nxt       = ST_SETTLE;
                        w_arm_start = 1'b1;
                    end
                end
                ST_SETTLE:    if (w_cnt_zero) w_nxt = ST_PRESAMPLE;
                ST_PRESAMPLE: if (w_cnt_zero) w_nxt = ST_WAIT_TRIG;
                ST_WAIT_TRIG: begin
                    if (w_trig_edge) begin
                        w_nxt = w_after_trig;
                    end else if ((r_timeout != '0) && w_cnt_zero) begin
                        w_nxt         = w_after_trig;
                        w_set_timeout = 1'b1;
                    end
                end
                ST_OFFSET:    if (w_cnt_zero) w_nxt = ST_CAPTURE;
                ST_CAPTURE: begin
                    if (capture_stop_i) begin
                        w_nxt          = ST_DONE;
                        w_set_overflow = r_stream;
                    end else if (r_stream && !arm_i) begin
                        w_nxt = ST_DONE;
                    end
                end
                ST_DONE:      if (!arm_i) w_nxt = ST_IDLE;
                default:      w_nxt = ST_IDLE;
            endcase
        end

        w_load       = (w_nxt != r_state);
        w_load_value = '0;
        case (w_nxt)
            ST_SETTLE:    w_load_value = c_settle_load;
            ST_PRESAMPLE: w_load_value = dwell_load(r_presample);
            ST_WAIT_TRIG: w_load_value = r_timeout;
            ST_OFFSET:    w_load_value = dwell_load(r_offset);
            default:      w_load_value = '0;
        endcase
    end

    // State register, registered outputs decoded from the next state,
    // edge-detect history, shadow registers and sticky flags
    always_ff @(posedge adc_sampleclk) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_trig_q    <= 1'b0;
            r_arm_q     <= 1'b0;
            r_presample <= '0;
            r_offset    <= '0;
            r_timeout   <= '0;
            r_stream    <= 1'b0;
            r_arm       <= 1'b0;
            r_go        <= 1'b0;
            r_armed     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timed_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_trig_q <= trig_i;
            r_arm_q  <= arm_i;
            r_state  <= w_nxt;
            r_arm    <= (w_nxt != ST_IDLE);
            r_busy   <= (w_nxt != ST_IDLE);
            r_go     <= (w_nxt == ST_CAPTURE);
            r_armed  <= (w_nxt == ST_WAIT_TRIG);
            r_done   <= (w_nxt == ST_DONE) && (r_state != ST_DONE);
            if (w_arm_start) begin
                r_presample <= presample_i;
                r_offset    <= offset_i;
                r_timeout   <= timeout_i;
                r_stream    <= stream_mode_i;
                r_timed_out <= 1'b0;
                r_overflow  <= 1'b0;
            end
            if (w_set_timeout) begin
                r_timed_out <= 1'b1;
            end
            if (w_set_overflow) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign arm_o           = r_arm;
    assign capture_go_o    = r_go;
    assign capture_armed_o = r_armed;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign timed_out_o     = r_timed_out;
    assign overflow_o      = r_overflow;
    assign state_o         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_capture_ctrl
// Description : Self-checking bench for adc_capture_ctrl. Each capture run is
//               described by its dwell parameters; the expected output
//               timeline is derived from interval arithmetic on those values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_capture_ctrl;

    localparam int CNT_W      = 32;
    localparam int ARM_SETTLE = 4;

    logic             adc_sampleclk = 1'b0;
    logic             reset_i;
    logic             arm_i;
    logic             abort_i;
    logic             trig_i;
    logic             stream_mode_i;
    logic [CNT_W-1:0] presample_i;
    logic [CNT_W-1:0] offset_i;
    logic [CNT_W-1:0] timeout_i;
    logic             capture_stop_i;
    logic             arm_o;
    logic             capture_go_o;
    logic             capture_armed_o;
    logic             busy_o;
    logic             done_o;
    logic             timed_out_o;
    logic             overflow_o;
    logic [2:0]       state_o;

    logic [9:0] w_obs;
    assign w_obs = {state_o, arm_o, capture_go_o, capture_armed_o, busy_o,
                    done_o, timed_out_o, overflow_o};

    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_to = 1'b0;
    logic prev_ov = 1'b0;

    always #5 adc_sampleclk = ~adc_sampleclk;

    adc_capture_ctrl #(
        .CNT_W      (CNT_W),
        .ARM_SETTLE (ARM_SETTLE)
    ) dut (
        .adc_sampleclk   (adc_sampleclk),
        .reset_i         (reset_i),
        .arm_i           (arm_i),
        .abort_i         (abort_i),
        .trig_i          (trig_i),
        .stream_mode_i   (stream_mode_i),
        .presample_i     (presample_i),
        .offset_i        (offset_i),
        .timeout_i       (timeout_i),
        .capture_stop_i  (capture_stop_i),
        .arm_o           (arm_o),
        .capture_go_o    (capture_go_o),
        .capture_armed_o (capture_armed_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .timed_out_o     (timed_out_o),
        .overflow_o      (overflow_o),
        .state_o         (state_o)
    );

    task automatic check_val(input string tag, input logic [9:0] got, input logic [9:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got {st,arm,go,armed,busy,done,to,ov}=%b_%b, expected %b_%b",
                     tag, got[9:7], got[6:0], want[9:7], want[6:0]);
        end
    endtask

    // One capture run. Edge 0 is the edge sampling the arm rising edge.
    // tdel : trigger edge this many edges after WAIT_TRIG entry (0 = none)
    // cl   : edges spent in CAPTURE before the ending event
    // endm : 0 = capture_stop_i, 1 = arm_i drop (stream), 2 = early arm drop
    // abst : abort in state 1..6, 7 = at a random edge, 0 = no abort
    // hold : keep trig_i high instead of random/low
    task automatic run_capture(input int rid, input int p, input int k, input int m,
                               input bit stream, input int tdel, input int cl,
                               input int endm, input int abst, input bit hold);
        int w, t, f, r, c, s, dn, ie, ab, lim, last;
        bit tout, sstop, has_t;
        logic [2:0] st;
        logic to, ov;
        logic [9:0] want;

        w     = ARM_SETTLE + ((p == 0) ? 1 : p);
        has_t = (tdel > 0);
        t     = w + tdel;
        f     = w + m + 1;
        if (has_t && (m == 0 || t <= f)) begin
            r = t; tout = 1'b0;
        end else begin
            r = f; tout = 1'b1;
        end
        c     = r + k;
        s     = c + cl;
        sstop = stream && (endm != 1);
        if (endm == 1)      dn = s;
        else if (endm == 2) dn = $urandom_range(c, 1);
        else                dn = s + 1 + $urandom_range(3, 0);
        ie = (s + 1 > dn) ? s + 1 : dn;
        case (abst)
            1:       ab = 1;
            2:       ab = ARM_SETTLE + 1;
            3:       ab = w + 1;
            4:       ab = r + 1;
            5:       ab = c + 1;
            6:       ab = s + 1;
            7:       ab = $urandom_range(ie - 1, 1);
            default: ab = 0;
        endcase
        lim  = (ab > 0) ? ab : (1 << 30);
        last = (ab > 0) ? ab + 3 : ie + 2;
        to   = prev_to;
        ov   = prev_ov;

        for (int e = -1; e <= last; e++) begin
            abort_i = (ab > 0) && (e == ab);
            arm_i   = (e >= 0) && (e < dn) && !((ab > 0) && (e > ab));
            if (e <= 0) begin
                presample_i   = CNT_W'(p);
                offset_i      = CNT_W'(k);
                timeout_i     = CNT_W'(m);
                stream_mode_i = stream;
            end else begin
                presample_i   = $urandom;
                offset_i      = $urandom;
                timeout_i     = $urandom;
                stream_mode_i = $urandom_range(1, 0);
            end
            if (e < w)           trig_i = hold ? 1'b1 : 1'($urandom_range(1, 0));
            else if (!has_t)     trig_i = hold;
            else if (e < t - 1)  trig_i = hold;
            else if (e == t - 1) trig_i = 1'b0;
            else                 trig_i = 1'b1;
            if (e > r && e <= c)       capture_stop_i = 1'b1;
            else if (e > c && e <= s)  capture_stop_i = (e == s) && (endm != 1);
            else                       capture_stop_i = 1'($urandom_range(1, 0));

            @(posedge adc_sampleclk);
            @(negedge adc_sampleclk);

            if (e < 0 || e >= lim)   st = 3'd0;
            else if (e < ARM_SETTLE) st = 3'd1;
            else if (e < w)          st = 3'd2;
            else if (e < r)          st = 3'd3;
            else if (e < c)          st = 3'd4;
            else if (e < s)          st = 3'd5;
            else if (e < ie)         st = 3'd6;
            else                     st = 3'd0;
            if (e >= 0) begin
                to = tout && (e >= r) && (r < lim);
                ov = sstop && (e >= s) && (s < lim);
            end
            want = {st, st != 3'd0, st == 3'd5, st == 3'd3, st != 3'd0,
                    (st == 3'd6) && (e == s), to, ov};
            check_val($sformatf("run%0d edge%0d", rid, e), w_obs, want);
        end
        abort_i = 1'b0;
        prev_to = to;
        prev_ov = ov;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p, k, m, tdel, cl, endm, abst;
        bit stream;

        reset_i        = 1'b1;
        arm_i          = 1'b0;
        abort_i        = 1'b0;
        trig_i         = 1'b1;
        stream_mode_i  = 1'b0;
        presample_i    = '0;
        offset_i       = '0;
        timeout_i      = '0;
        capture_stop_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge adc_sampleclk);
            @(negedge adc_sampleclk);
            check_val($sformatf("reset%0d", i), w_obs, 10'd0);
        end
        reset_i = 1'b0;

        // trig_i high since reset never counts as an edge; timeout ends it
        run_capture(0, 3, 0, 8, 1'b0, 0, 3, 0, 0, 1'b1);
        // presample 10, offset 0, trigger then stop
        run_capture(1, 10, 0, 0, 1'b0, 16, 19, 0, 0, 1'b0);
        // offset 5 with stop held during OFFSET
        run_capture(2, 2, 5, 0, 1'b0, 4, 5, 0, 0, 1'b0);
        // timeout forced capture, then trigger coincident with timeout
        run_capture(3, 0, 0, 20, 1'b0, 0, 4, 0, 0, 1'b0);
        run_capture(4, 4, 0, 20, 1'b0, 21, 4, 0, 0, 1'b0);
        run_capture(5, 1, 3, 6, 1'b0, 7, 2, 0, 0, 1'b0);
        // trigger must fall and rise again after being high on entry
        run_capture(6, 2, 0, 0, 1'b0, 5, 2, 0, 0, 1'b1);
        // stream: stop ends with overflow, then arm drop ends without
        run_capture(7, 2, 1, 0, 1'b1, 3, 4, 0, 0, 1'b0);
        run_capture(8, 2, 1, 0, 1'b1, 3, 4, 1, 0, 1'b0);
        // abort in each non-idle state
        for (int a = 1; a <= 6; a++) begin
            run_capture(10 + a, 3, 2, 9, 1'b1, 12, 3, 0, a, 1'b0);
        end

        for (int n = 0; n < 30; n++) begin
            p      = $urandom_range(12, 0);
            k      = $urandom_range(6, 0);
            m      = ($urandom_range(1, 0) == 1) ? $urandom_range(25, 1) : 0;
            stream = 1'($urandom_range(1, 0));
            if (m == 0)                         tdel = $urandom_range(20, 1);
            else if ($urandom_range(1, 0) == 1) tdel = $urandom_range(m + 3, 1);
            else                                tdel = 0;
            cl     = $urandom_range(10, 1);
            if (stream) endm = $urandom_range(1, 0);
            else        endm = ($urandom_range(3, 0) == 0) ? 2 : 0;
            abst   = ($urandom_range(3, 0) == 0) ? 7 : 0;
            run_capture(100 + n, p, k, m, stream, tdel, cl, endm, abst, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
